spi_sram_ctrl: RTL and testbench

Memory-side responder for the controller's memory-operation handshake. The block accepts `mem_ctrl_op` requests (read/write) from the CPU control unit, runs the matching SPI transaction against an external 23LC-style serial SRAM, and returns `mem_op_done` plus read data on the data bus. It sits between the control unit and the chip's SPI pins, replacing any on-chip memory.

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/spi_shift_reg.sv | 41 ++++
 rtl/spi_sram_ctrl.sv | 149 ++++++++++++++
 tb/tb_spi_sram_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: control-unit memory operations plus the serial SRAM
// responder's command bytes and state encoding.
package cpu_pkg;

   typedef enum logic [1:0] {
      MEM_NOP   = 2'b00,
      MEM_READ  = 2'b01,
      MEM_WRITE = 2'b10
   } mem_ctrl_op_e;

   localparam logic [7:0] SPI_CMD_READ  = 8'h03;
   localparam logic [7:0] SPI_CMD_WRITE = 8'h02;

   // Frame = command byte, 16-bit address, one data byte.
   localparam int SPI_FRAME_BITS = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } spi_sram_state_e;

endpackage

// File: rtl/spi_shift_reg.sv
// SPI datapath: 32-bit parallel-load transmit shifter (MSB first, zero fill)
// and 8-bit receive shifter; the parent FSM supplies all enables.
module spi_shift_reg (
   input  logic        clock,
   input  logic        reset,
   input  logic        load,
   input  logic [31:0] load_data,
   input  logic        shift_en,
   input  logic        sample_en,
   input  logic        miso,
   output logic        mosi,
   output logic [7:0]  rx_data
);

   logic [31:0] tx_q;
   logic [7:0]  rx_q;

   // Zero fill means MOSI returns to 0 after the final shift, so the line is
   // already low when chip select rises.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         tx_q <= '0;
      end else if (load) begin
         tx_q <= load_data;
      end else if (shift_en) begin
         tx_q <= {tx_q[30:0], 1'b0};
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rx_q <= '0;
      end else if (sample_en) begin
         rx_q <= {rx_q[6:0], miso};
      end
   end

   assign mosi    = tx_q[31];
   assign rx_data = rx_q;

endmodule

// File: rtl/spi_sram_ctrl.sv
// Memory-side responder: turns control-unit read/write requests into single-byte
// 23LC-style SPI transactions (mode 0, SCLK = clock/2) and pulses mem_op_done.
//
// Handshake: the requester holds mem_ctrl_op (READ/WRITE) until it sees the
// one-cycle mem_op_done pulse; the request is accepted on the first IDLE edge,
// addr/data_in are sampled only then, and the request is ignored in DONE.
module spi_sram_ctrl
   import cpu_pkg::*;
#(
   parameter int DATA_BUS_WIDTH = 8,
   parameter int ADDR_WIDTH     = 16
) (
   input  logic                      clock,
   input  logic                      reset,
   input  mem_ctrl_op_e              mem_ctrl_op,
   input  logic [ADDR_WIDTH-1:0]     addr,
   input  logic [DATA_BUS_WIDTH-1:0] data_in,
   output logic [DATA_BUS_WIDTH-1:0] data_out,
   output logic                      mem_op_done,
   output logic                      spi_cs_n,
   output logic                      spi_sclk,
   output logic                      spi_mosi,
   input  logic                      spi_miso,
   output spi_sram_state_e           dbg_state
);

   spi_sram_state_e           state_q, state_d;
   logic                      phase_q, phase_d;
   logic [4:0]                bit_cnt_q, bit_cnt_d;
   logic                      is_read_q, is_read_d;
   logic                      cs_n_q, cs_n_d;
   logic                      sclk_q, sclk_d;
   logic                      done_q, done_d;
   logic [DATA_BUS_WIDTH-1:0] data_out_q, data_out_d;
   logic                      load, shift_en, sample_en;
   logic [31:0]               frame;
   logic [7:0]                rx_data;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         phase_q    <= 1'b0;
         bit_cnt_q  <= '0;
         is_read_q  <= 1'b0;
         cs_n_q     <= 1'b1;
         sclk_q     <= 1'b0;
         done_q     <= 1'b0;
         data_out_q <= '0;
      end else begin
         state_q    <= state_d;
         phase_q    <= phase_d;
         bit_cnt_q  <= bit_cnt_d;
         is_read_q  <= is_read_d;
         cs_n_q     <= cs_n_d;
         sclk_q     <= sclk_d;
         done_q     <= done_d;
         data_out_q <= data_out_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      phase_d    = phase_q;
      bit_cnt_d  = bit_cnt_q;
      is_read_d  = is_read_q;
      cs_n_d     = cs_n_q;
      sclk_d     = sclk_q;
      done_d     = 1'b0;
      data_out_d = data_out_q;
      load       = 1'b0;
      shift_en   = 1'b0;
      sample_en  = 1'b0;
      frame      = {SPI_CMD_WRITE, addr[15:0], data_in};

      case (state_q)
         IDLE: begin
            cs_n_d    = 1'b1;
            sclk_d    = 1'b0;
            phase_d   = 1'b0;
            bit_cnt_d = '0;
            if (mem_ctrl_op == MEM_READ || mem_ctrl_op == MEM_WRITE) begin
               is_read_d = (mem_ctrl_op == MEM_READ);
               if (mem_ctrl_op == MEM_READ) begin
                  frame = {SPI_CMD_READ, addr[15:0], 8'h00};
               end
               load    = 1'b1;
               cs_n_d  = 1'b0;
               state_d = SHIFT;
            end
         end

         SHIFT: begin
            if (!phase_q) begin
               // Rising SCLK edge: the SRAM's MISO is sampled here.
               sclk_d    = 1'b1;
               sample_en = 1'b1;
               phase_d   = 1'b1;
            end else begin
               sclk_d   = 1'b0;
               shift_en = 1'b1;
               phase_d  = 1'b0;
               if (bit_cnt_q == 5'(SPI_FRAME_BITS - 1)) begin
                  state_d = DONE;
                  cs_n_d  = 1'b1;
                  done_d  = 1'b1;
                  if (is_read_q) begin
                     data_out_d = rx_data;
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q + 5'd1;
               end
            end
         end

         DONE: begin
            state_d   = IDLE;
            cs_n_d    = 1'b1;
            sclk_d    = 1'b0;
            phase_d   = 1'b0;
            bit_cnt_d = '0;
         end

         default: begin
            state_d = IDLE;
            cs_n_d  = 1'b1;
            sclk_d  = 1'b0;
         end
      endcase
   end

   spi_shift_reg u_shift (
      .clock     (clock),
      .reset     (reset),
      .load      (load),
      .load_data (frame),
      .shift_en  (shift_en),
      .sample_en (sample_en),
      .miso      (spi_miso),
      .mosi      (spi_mosi),
      .rx_data   (rx_data)
   );

   assign data_out    = data_out_q;
   assign mem_op_done = done_q;
   assign spi_cs_n    = cs_n_q;
   assign spi_sclk    = sclk_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_spi_sram_ctrl.sv
// Directed bench for spi_sram_ctrl with a behavioural 23LC-style SRAM that
// records MOSI on SCLK rise and serves a chosen read byte.
module tb_spi_sram_ctrl;
   import cpu_pkg::*;

   logic            clock;
   logic            reset;
   mem_ctrl_op_e    mem_ctrl_op;
   logic [15:0]     addr;
   logic [7:0]      data_in;
   logic [7:0]      data_out;
   logic            mem_op_done;
   logic            spi_cs_n;
   logic            spi_sclk;
   logic            spi_mosi;
   logic            spi_miso;
   spi_sram_state_e dbg_state;

   int tests  = 0;
   int failed = 0;

   logic [31:0] exp_q[$];

   spi_sram_ctrl #(.DATA_BUS_WIDTH(8), .ADDR_WIDTH(16)) dut (
      .clock       (clock),
      .reset       (reset),
      .mem_ctrl_op (mem_ctrl_op),
      .addr        (addr),
      .data_in     (data_in),
      .data_out    (data_out),
      .mem_op_done (mem_op_done),
      .spi_cs_n    (spi_cs_n),
      .spi_sclk    (spi_sclk),
      .spi_mosi    (spi_mosi),
      .spi_miso    (spi_miso),
      .dbg_state   (dbg_state)
   );

   // clock / watchdog
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   // SRAM model: bit counter and MOSI capture, cleared while deselected
   logic [5:0]  sclk_cnt;
   logic [31:0] mosi_cap;
   logic [7:0]  sram_byte;
   logic [2:0]  miso_idx;

   always @(posedge spi_sclk or posedge spi_cs_n) begin
      if (spi_cs_n) begin
         sclk_cnt <= '0;
         mosi_cap <= '0;
      end else begin
         sclk_cnt <= sclk_cnt + 6'd1;
         mosi_cap <= {mosi_cap[30:0], spi_mosi};
      end
   end

   always_comb begin
      miso_idx = 3'(6'd31 - sclk_cnt);
      spi_miso = (sclk_cnt >= 6'd24 && sclk_cnt < 6'd32) ? sram_byte[miso_idx] : 1'b1;
   end

   // Event counters sampled on the active edge
   int done_cnt   = 0;
   int cs_low_cnt = 0;
   int sclk_hi_cnt = 0;

   always @(posedge clock) begin
      if (mem_op_done === 1'b1) done_cnt++;
      if (spi_cs_n !== 1'b1) cs_low_cnt++;
      if (spi_sclk !== 1'b0) sclk_hi_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Drives one request from just before its accepting edge to one edge after
   // done; with hold=1 the request stays asserted for a back-to-back op.
   task automatic do_op(input mem_ctrl_op_e op, input logic [15:0] a, input logic [7:0] d,
                        input logic [7:0] rb, input logic [31:0] exp_frame,
                        input logic [7:0] exp_dout, input bit hold);
      logic [31:0] exp_f;
      sram_byte   = rb;
      mem_ctrl_op = op;
      addr        = a;
      data_in     = d;
      exp_q.push_back(exp_frame);
      @(posedge clock); #1;
      check("edge0_cs_n", 32'(spi_cs_n), 32'd0);
      check("edge0_sclk", 32'(spi_sclk), 32'd0);
      check("edge0_mosi", 32'(spi_mosi), 32'(exp_frame[31]));
      addr    = ~a;
      data_in = ~d;
      repeat (63) @(posedge clock);
      #1;
      exp_f = exp_q.pop_front();
      check("edge63_done", 32'(mem_op_done), 32'd0);
      check("edge63_sclk", 32'(spi_sclk), 32'd1);
      check("mosi_frame", mosi_cap, exp_f);
      check("sclk_pulses", 32'(sclk_cnt), 32'd32);
      @(posedge clock); #1;
      check("edge64_done", 32'(mem_op_done), 32'd1);
      check("edge64_cs_n", 32'(spi_cs_n), 32'd1);
      check("edge64_sclk", 32'(spi_sclk), 32'd0);
      check("edge64_mosi", 32'(spi_mosi), 32'd0);
      check("edge64_data_out", 32'(data_out), 32'(exp_dout));
      if (!hold) mem_ctrl_op = MEM_NOP;
      @(posedge clock); #1;
      check("edge65_done", 32'(mem_op_done), 32'd0);
      check("edge65_cs_n", 32'(spi_cs_n), 32'd1);
      check("edge65_state", 32'(dbg_state), 32'(IDLE));
   endtask

   int snap_done;
   int snap_cs;
   int snap_sclk;

   initial begin
      reset       = 1'b0;
      mem_ctrl_op = MEM_NOP;
      addr        = '0;
      data_in     = '0;
      sram_byte   = '0;

      // Asynchronous reset asserted mid-cycle, before any clock edge
      #3 reset = 1'b1;
      #1;
      check("rst_cs_n", 32'(spi_cs_n), 32'd1);
      check("rst_sclk", 32'(spi_sclk), 32'd0);
      check("rst_mosi", 32'(spi_mosi), 32'd0);
      check("rst_done", 32'(mem_op_done), 32'd0);
      check("rst_data_out", 32'(data_out), 32'd0);
      check("rst_state", 32'(dbg_state), 32'(IDLE));
      repeat (2) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);

      // Write leaves data_out at its reset value
      do_op(MEM_WRITE, 16'h1234, 8'hA5, 8'hFF, 32'h021234A5, 8'h00, 1'b0);
      // Read returns the SRAM byte
      do_op(MEM_READ, 16'h00FF, 8'h77, 8'h3C, 32'h0300FF00, 8'h3C, 1'b0);

      // Back-to-back reads with the request held through DONE
      snap_done = done_cnt;
      do_op(MEM_READ, 16'hABCD, 8'h00, 8'hC3, 32'h03ABCD00, 8'hC3, 1'b1);
      do_op(MEM_READ, 16'h8001, 8'h00, 8'h81, 32'h03800100, 8'h81, 1'b0);
      check("b2b_done_count", 32'(done_cnt - snap_done), 32'd2);

      // Write keeps the last read byte
      do_op(MEM_WRITE, 16'hBEEF, 8'h11, 8'h00, 32'h02BEEF11, 8'h81, 1'b0);

      // Reset during bit 11 aborts with no done pulse
      snap_done   = done_cnt;
      mem_ctrl_op = MEM_WRITE;
      addr        = 16'h4321;
      data_in     = 8'h77;
      @(posedge clock);
      repeat (22) @(posedge clock);
      #2 reset = 1'b1;
      #1;
      check("abort_cs_n", 32'(spi_cs_n), 32'd1);
      check("abort_sclk", 32'(spi_sclk), 32'd0);
      check("abort_mosi", 32'(spi_mosi), 32'd0);
      check("abort_data_out", 32'(data_out), 32'd0);
      check("abort_state", 32'(dbg_state), 32'(IDLE));
      mem_ctrl_op = MEM_NOP;
      @(negedge clock);
      reset = 1'b0;
      repeat (5) @(negedge clock);
      check("abort_no_done", 32'(done_cnt - snap_done), 32'd0);
      do_op(MEM_WRITE, 16'h0001, 8'h5A, 8'h00, 32'h0200015A, 8'h00, 1'b0);

      // NOP and an undefined encoding never start a frame
      snap_done = done_cnt;
      snap_cs   = cs_low_cnt;
      snap_sclk = sclk_hi_cnt;
      mem_ctrl_op = MEM_NOP;
      repeat (10) @(negedge clock);
      mem_ctrl_op = mem_ctrl_op_e'(2'b11);
      repeat (10) @(negedge clock);
      mem_ctrl_op = MEM_NOP;
      check("nop_cs_low_cycles", 32'(cs_low_cnt - snap_cs), 32'd0);
      check("nop_sclk_cycles", 32'(sclk_hi_cnt - snap_sclk), 32'd0);
      check("nop_done", 32'(done_cnt - snap_done), 32'd0);
      check("nop_state", 32'(dbg_state), 32'(IDLE));

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
